instr_fetch_unit: RTL and testbench

- Fetch stage that sits directly upstream of the instruction decoder.
- Keeps the program counter and issues word reads to instruction memory.
- Buffers returned words in a small in-order prefetch FIFO and presents them on InstructionBus with a valid/ready handshake.
- Supports a redirect (jump/branch) that flushes the FIFO and drops in-flight memory responses.

---
 rtl/instr_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, memory read issue, in-order prefetch FIFO.
// Redirect flushes the FIFO and drops responses still in flight.
module instr_fetch_unit #(
   parameter int                ADDR_W     = 16,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              MemReq,
   output logic [ADDR_W-1:0] MemAddr,
   input  logic [31:0]       MemData,
   input  logic              MemValid,
   output logic [31:0]       InstructionBus,
   output logic              InstrValid,
   output logic [ADDR_W-1:0] InstrPC,
   input  logic              DecoderReady,
   input  logic              Redirect,
   input  logic [ADDR_W-1:0] RedirectAddr
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_FLUSH
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     r_out;
   logic [CW-1:0]     r_discard;
   logic [PW-1:0]     r_rd;
   logic [PW-1:0]     r_wr;
   logic [PW-1:0]     r_tq_rd;
   logic [PW-1:0]     r_tq_wr;
   logic [31:0]       r_fdata [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_fpc   [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_tq    [FIFO_DEPTH];
   logic [31:0]       r_last_data;
   logic [ADDR_W-1:0] r_last_pc;

   logic [CW:0]       w_occ;
   logic              w_rsp;
   logic              w_push;
   logic              w_pop;
   logic              w_req;
   logic              w_valid;
   logic [CW-1:0]     w_disc_new;

   // A response only counts when a read is actually outstanding.
   assign w_occ      = {1'b0, r_count} + {1'b0, r_out};
   assign w_rsp      = MemValid && (r_out != '0);
   assign w_push     = w_rsp && (r_state == S_FETCH) && !Redirect;
   assign w_valid    = (r_count != '0);
   assign w_pop      = w_valid && DecoderReady && !Redirect;
   assign w_disc_new = r_out - CW'(w_rsp);

   assign MemReq         = w_req;
   assign MemAddr        = r_pc;
   assign InstrValid     = w_valid;
   assign InstructionBus = w_valid ? r_fdata[r_rd] : r_last_data;
   assign InstrPC        = w_valid ? r_fpc[r_rd] : r_last_pc;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and request issue; Redirect overrides every state.
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      unique case (r_state)
         S_IDLE: w_state_nxt = S_FETCH;
         S_FETCH: begin
            w_req = !Redirect && (w_occ < (CW+1)'(FIFO_DEPTH));
         end
         S_FLUSH: begin
            if (w_rsp && r_discard == CW'(1)) w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (Redirect) begin
         w_state_nxt = (w_disc_new != '0) ? S_FLUSH : S_FETCH;
      end
   end

   // PC, occupancy counters, pointers and the last-popped holding regs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc        <= RESET_PC;
         r_count     <= '0;
         r_out       <= '0;
         r_discard   <= '0;
         r_rd        <= '0;
         r_wr        <= '0;
         r_tq_rd     <= '0;
         r_tq_wr     <= '0;
         r_last_data <= '0;
         r_last_pc   <= '0;
      end else if (Redirect) begin
         r_pc      <= RedirectAddr;
         r_count   <= '0;
         r_rd      <= '0;
         r_wr      <= '0;
         r_out     <= w_disc_new;
         r_discard <= w_disc_new;
         if (w_rsp) r_tq_rd <= r_tq_rd + PW'(1);
      end else begin
         if (w_req) begin
            r_pc    <= r_pc + ADDR_W'(1);
            r_tq_wr <= r_tq_wr + PW'(1);
         end
         if (w_rsp) r_tq_rd <= r_tq_rd + PW'(1);
         r_out <= r_out + CW'(w_req) - CW'(w_rsp);
         if (r_state == S_FLUSH && w_rsp) begin
            r_discard <= r_discard - CW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_push) r_wr <= r_wr + PW'(1);
         if (w_pop) begin
            r_rd        <= r_rd + PW'(1);
            r_last_data <= r_fdata[r_rd];
            r_last_pc   <= r_fpc[r_rd];
         end
      end
   end

   // Address tag queue: one entry per outstanding read, in issue order.
   always_ff @(posedge clk) begin
      if (rst_n && w_req) r_tq[r_tq_wr] <= r_pc;
   end

   // Prefetch FIFO storage: word plus the address it was fetched from.
   always_ff @(posedge clk) begin
      if (rst_n && w_push) begin
         r_fdata[r_wr] <= MemData;
         r_fpc[r_wr]   <= r_tq[r_tq_rd];
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random-latency in-order memory plus a
// queue-based reference of the delivered instruction stream.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemReq;
   logic [15:0] MemAddr;
   logic [31:0] MemData = '0;
   logic        MemValid = 1'b0;
   logic [31:0] ib;
   logic        iv;
   logic [15:0] ipc;
   logic        ready = 1'b0;
   logic        redir = 1'b0;
   logic [15:0] raddr = '0;

   logic        w_rst_n = 1'b0;
   logic        w_req;
   logic [3:0]  w_addr;
   logic [31:0] w_data = '0;
   logic        w_valid = 1'b0;
   logic [31:0] w_ib;
   logic        w_iv;
   logic [3:0]  w_ipc;
   logic        w_ready = 1'b0;
   logic        w_redir = 1'b0;
   logic [3:0]  w_raddr = '0;

   always #5 clk = ~clk;

   instr_fetch_unit u_dut (
      .clk(clk), .rst_n(rst_n),
      .MemReq(MemReq), .MemAddr(MemAddr),
      .MemData(MemData), .MemValid(MemValid),
      .InstructionBus(ib), .InstrValid(iv), .InstrPC(ipc),
      .DecoderReady(ready), .Redirect(redir), .RedirectAddr(raddr)
   );

   instr_fetch_unit #(.ADDR_W(4), .FIFO_DEPTH(4), .RESET_PC(4'd14)) u_wrap (
      .clk(clk), .rst_n(w_rst_n),
      .MemReq(w_req), .MemAddr(w_addr),
      .MemData(w_data), .MemValid(w_valid),
      .InstructionBus(w_ib), .InstrValid(w_iv), .InstrPC(w_ipc),
      .DecoderReady(w_ready), .Redirect(w_redir), .RedirectAddr(w_raddr)
   );

   typedef struct {
      logic [15:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [15:0] mq[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          since_rst = 0;
   int          drop = 0;
   int          last_due = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          armed = 0;
   bit          rst_seen = 0;
   bit          stray = 0;
   bit          real_now = 0;
   logic [15:0] req_pc = '0;
   logic [15:0] exp_pc = '0;
   logic [15:0] last_pc = '0;
   logic [31:0] last_data = '0;

   function automatic logic [31:0] memf(input logic [15:0] a);
      if (a == 16'd3) return 32'hC464AD48;
      return {a, a ^ 16'h5A3C};
   endfunction

   function automatic logic [31:0] wmem(input logic [3:0] a);
      return 32'hA5A50000 | {28'd0, a};
   endfunction

   task automatic prep();
      real_now = 0;
      if (stray) begin
         MemValid = 1'b1;
         MemData  = $urandom;
         stray    = 0;
      end else if (pend.size() != 0 && pend[0].due <= cyc) begin
         MemValid = 1'b1;
         MemData  = memf(pend[0].addr);
         real_now = 1;
      end else begin
         MemValid = 1'b0;
         MemData  = $urandom;
      end
   endtask

   // One clock: check outputs against the model, advance the model, clock.
   task automatic tick();
      logic  exp_req;
      bit    pop;
      pend_t r;
      int    d;
      #1;
      if (!rst_n) begin
         if (rst_seen) begin
            total++;
            if (MemReq !== 1'b0) begin
               bad++;
               $display("FAIL rst_memreq got=%0b exp=0", MemReq);
            end
            total++;
            if (MemAddr !== 16'd0) begin
               bad++;
               $display("FAIL rst_memaddr got=%0h exp=0", MemAddr);
            end
            total++;
            if (iv !== 1'b0 || ib !== 32'd0 || ipc !== 16'd0) begin
               bad++;
               $display("FAIL rst_instr got iv=%0b ib=%0h pc=%0h exp 0/0/0",
                        iv, ib, ipc);
            end
         end
         pend.delete();
         mq.delete();
         drop      = 0;
         since_rst = 0;
         req_pc    = '0;
         exp_pc    = '0;
         last_pc   = '0;
         last_data = '0;
         rst_seen  = 1;
         armed     = 1;
      end else if (armed) begin
         rst_seen = 0;
         exp_req = (since_rst >= 1) && !redir && drop == 0 &&
                   (mq.size() + pend.size() < 4);
         total++;
         if (MemReq !== exp_req) begin
            bad++;
            $display("FAIL memreq cyc=%0d got=%0b exp=%0b",
                     cyc, MemReq, exp_req);
         end
         total++;
         if (MemAddr !== req_pc) begin
            bad++;
            $display("FAIL memaddr cyc=%0d got=%0h exp=%0h",
                     cyc, MemAddr, req_pc);
         end
         total++;
         if (iv !== (mq.size() != 0)) begin
            bad++;
            $display("FAIL instrvalid cyc=%0d got=%0b exp=%0b",
                     cyc, iv, mq.size() != 0);
         end
         total++;
         if (mq.size() != 0) begin
            if (ipc !== mq[0] || ib !== memf(mq[0])) begin
               bad++;
               $display("FAIL head cyc=%0d got=%0h/%0h exp=%0h/%0h",
                        cyc, ipc, ib, mq[0], memf(mq[0]));
            end
         end else if (ipc !== last_pc || ib !== last_data) begin
            bad++;
            $display("FAIL hold cyc=%0d got=%0h/%0h exp=%0h/%0h",
                     cyc, ipc, ib, last_pc, last_data);
         end
         pop = mq.size() != 0 && ready && !redir;
         if (pop) begin
            total++;
            if (ipc !== exp_pc) begin
               bad++;
               $display("FAIL order cyc=%0d got=%0h exp=%0h",
                        cyc, ipc, exp_pc);
            end
            last_pc   = mq[0];
            last_data = memf(mq[0]);
            void'(mq.pop_front());
            exp_pc = exp_pc + 16'd1;
         end
         if (real_now) begin
            r = pend.pop_front();
            if (!redir) begin
               if (drop > 0) drop--;
               else          mq.push_back(r.addr);
            end
         end
         if (redir) begin
            mq.delete();
            drop   = pend.size();
            req_pc = raddr;
            exp_pc = raddr;
         end else if (MemReq) begin
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{MemAddr, d});
            req_pc = req_pc + 16'd1;
         end
         since_rst++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      prep();
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      ready = 1'b1;
      redir = 1'b0;
      repeat (n) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      lat_min = 1;
      lat_max = 1;
      do_reset(3);
      #1;
      total++;
      if (MemReq !== 1'b0) begin
         bad++;
         $display("FAIL start_idle got=%0b exp=0", MemReq);
      end
      tick();
      #1;
      total++;
      if (MemReq !== 1'b1 || MemAddr !== 16'd0) begin
         bad++;
         $display("FAIL start_req got=%0b/%0h exp=1/0", MemReq, MemAddr);
      end
      repeat (10) tick();
   endtask

   task automatic test_stream();
      int  gaps;
      bit  seen;
      bit  saw3;
      lat_min = 1;
      lat_max = 1;
      do_reset(2);
      gaps = 0;
      seen = 0;
      saw3 = 0;
      repeat (40) begin
         #1;
         if (iv) seen = 1;
         else if (seen) gaps++;
         if (iv && ipc == 16'd3 && ib == 32'hC464AD48) saw3 = 1;
         tick();
      end
      total++;
      if (gaps != 0 || !seen) begin
         bad++;
         $display("FAIL stream_gaps got=%0d seen=%0b exp=0 seen=1",
                  gaps, seen);
      end
      total++;
      if (!saw3) begin
         bad++;
         $display("FAIL stream_word3 got=absent exp=C464AD48@3");
      end
   endtask

   task automatic test_backpressure();
      int nreq;
      lat_min = 1;
      lat_max = 3;
      do_reset(2);
      ready = 1'b0;
      nreq  = 0;
      repeat (20) begin
         #1;
         if (MemReq) nreq++;
         tick();
      end
      total++;
      if (nreq != 4) begin
         bad++;
         $display("FAIL bp_reqs got=%0d exp=4", nreq);
      end
      #1;
      total++;
      if (iv !== 1'b1 || ipc !== 16'd0) begin
         bad++;
         $display("FAIL bp_head got=%0b/%0h exp=1/0", iv, ipc);
      end
      ready = 1'b1;
      repeat (30) tick();
      total++;
      if (exp_pc <= 16'd4) begin
         bad++;
         $display("FAIL bp_resume got=%0h exp>4", exp_pc);
      end
   endtask

   task automatic test_redirect();
      int  n;
      bit  found;
      lat_min = 3;
      lat_max = 3;
      do_reset(2);
      n = 0;
      while (pend.size() < 3 && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (pend.size() != 3) begin
         bad++;
         $display("FAIL redir_inflight got=%0d exp=3", pend.size());
      end
      redir = 1'b1;
      raddr = 16'h0100;
      tick();
      redir = 1'b0;
      #1;
      total++;
      if (iv !== 1'b0) begin
         bad++;
         $display("FAIL redir_flush got=%0b exp=0", iv);
      end
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         #1;
         if (iv) begin
            found = 1;
            total++;
            if (ipc !== 16'h0100) begin
               bad++;
               $display("FAIL redir_first got=%0h exp=100", ipc);
            end
         end else begin
            tick();
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL redir_timeout got=none exp=instr");
      end
      repeat (20) tick();
   endtask

   task automatic test_random();
      lat_min = 1;
      lat_max = 4;
      do_reset(2);
      repeat (400) begin
         ready = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 29) == 0);
         raddr = 16'($urandom);
         tick();
      end
      redir = 1'b0;
      ready = 1'b1;
      repeat (20) tick();
   endtask

   task automatic test_reset_mid();
      int n;
      bit found;
      lat_min = 2;
      lat_max = 2;
      do_reset(2);
      ready = 1'b0;
      n = 0;
      while (!(pend.size() == 2 && mq.size() >= 1) && n < 30) begin
         tick();
         n++;
      end
      total++;
      if (pend.size() != 2 || mq.size() < 1) begin
         bad++;
         $display("FAIL mid_setup got=%0d/%0d exp=2/>=1",
                  pend.size(), mq.size());
      end
      rst_n = 1'b0;
      stray = 1;
      tick();
      rst_n = 1'b1;
      #1;
      total++;
      if (iv !== 1'b0 || MemReq !== 1'b0 || MemAddr !== 16'd0 ||
          ib !== 32'd0 || ipc !== 16'd0) begin
         bad++;
         $display("FAIL mid_reset got=%0b/%0b/%0h/%0h/%0h exp=0/0/0/0/0",
                  iv, MemReq, MemAddr, ib, ipc);
      end
      stray = 1;
      tick();
      ready = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         #1;
         if (iv) begin
            found = 1;
            total++;
            if (ipc !== 16'd0 || ib !== memf(16'd0)) begin
               bad++;
               $display("FAIL mid_restart got=%0h/%0h exp=0/%0h",
                        ipc, ib, memf(16'd0));
            end
         end else begin
            tick();
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL mid_timeout got=none exp=instr");
      end
      repeat (10) tick();
   endtask

   task automatic test_wrap();
      logic [3:0]  wexp[4];
      logic [3:0]  got_pc[4];
      logic [31:0] got_d[4];
      logic        nv;
      logic [3:0]  na;
      int          cnt;
      wexp = '{4'd14, 4'd15, 4'd0, 4'd1};
      w_ready = 1'b1;
      w_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      w_rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40 && cnt < 4; i++) begin
         #1;
         if (w_iv) begin
            got_pc[cnt] = w_ipc;
            got_d[cnt]  = w_ib;
            cnt++;
         end
         nv = w_req;
         na = w_addr;
         @(negedge clk);
         w_valid = nv;
         w_data  = wmem(na);
      end
      total++;
      if (cnt != 4) begin
         bad++;
         $display("FAIL wrap_count got=%0d exp=4", cnt);
      end
      for (int i = 0; i < cnt; i++) begin
         total++;
         if (got_pc[i] !== wexp[i] || got_d[i] !== wmem(wexp[i])) begin
            bad++;
            $display("FAIL wrap_seq idx=%0d got=%0d/%0h exp=%0d/%0h",
                     i, got_pc[i], got_d[i], wexp[i], wmem(wexp[i]));
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
